dmem_ctrl: RTL

Sequencing controller between the MIPS MEM stage and a word-wide, word-write-only synchronous data memory. Accepts one load/store per handshake, formats sub-word loads (lb/lbu/lh/lhu), and performs read-modify-write for sb/sh because the memory has no byte enables. Flags misaligned or unknown ops without touching memory. Holds the pipeline via `stall` while busy.

---
 rtl/dmem_ctrl_pkg.sv | 39 +++
 rtl/dmem_ctrl_lane_fmt.sv | 36 +++
 rtl/dmem_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: MIPS load/store opcodes,
// FSM state encodings and request classification helpers.
package dmem_ctrl_pkg;

    localparam logic [5:0] op_lb  = 6'h20;
    localparam logic [5:0] op_lh  = 6'h21;
    localparam logic [5:0] op_lw  = 6'h23;
    localparam logic [5:0] op_lbu = 6'h24;
    localparam logic [5:0] op_lhu = 6'h25;
    localparam logic [5:0] op_sb  = 6'h28;
    localparam logic [5:0] op_sh  = 6'h29;
    localparam logic [5:0] op_sw  = 6'h2B;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == op_lb) || (op == op_lbu) || (op == op_lh) ||
               (op == op_lhu) || (op == op_lw);
    endfunction

    // Unknown opcodes are reported as errors just like misaligned accesses.
    function automatic logic req_is_err(input logic [5:0] op, input logic [1:0] off);
        logic err;
        case (op)
            op_lb, op_lbu, op_sb: err = 1'b0;
            op_lh, op_lhu, op_sh: err = off[0];
            op_lw, op_sw:         err = (off != 2'b00);
            default:              err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_ctrl_lane_fmt.sv
// Little-endian lane handling: formats sub-word loads and merges sub-word
// store data into a full memory word for read-modify-write.
module lane_fmt
    import dmem_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_word,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte   = word[{off, 3'b000} +: 8];
        sel_half   = off[1] ? word[31:16] : word[15:0];
        load_word  = word;
        store_word = word;
        case (op)
            op_lb:  load_word = {{24{sel_byte[7]}}, sel_byte};
            op_lbu: load_word = {24'h0, sel_byte};
            op_lh:  load_word = {{16{sel_half[15]}}, sel_half};
            op_lhu: load_word = {16'h0, sel_half};
            op_sb:  store_word[{off, 3'b000} +: 8] = wdata[7:0];
            op_sh: begin
                if (off[1]) store_word[31:16] = wdata[15:0];
                else        store_word[15:0]  = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Serial load/store sequencer between the MEM stage and a word-only synchronous
// data memory; sub-word stores are done as read-modify-write.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [5:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state, next_state;
    logic [5:0]        op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       load_word, store_word;
    logic              accept, acc_err;
    logic              unused_addr_bits;

    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};
    assign accept  = req_valid & req_ready;
    assign acc_err = req_is_err(req_op, req_addr[1:0]);

    lane_fmt u_lane_fmt (
        .op         (op_q),
        .off        (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .load_word  (load_word),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (acc_err)               next_state = ST_RESP;
                    else if (req_op == op_sw)  next_state = ST_WR;
                    else                       next_state = ST_RD;
                end
            end
            ST_RD:   next_state = ST_CAP;
            ST_CAP:  next_state = op_is_load(op_q) ? ST_RESP : ST_WR;
            ST_WR:   next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // The memory read data is only valid in CAP, so both load extraction and
    // the store merge are captured on the edge that leaves CAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
            end
            if (state == ST_CAP && !op_is_load(op_q))
                wdata_q <= store_word;
            if (next_state == ST_RESP) begin
                resp_err   <= (state == ST_IDLE) ? acc_err : 1'b0;
                resp_rdata <= (state == ST_CAP && op_is_load(op_q)) ? load_word : 32'h0;
            end
        end
    end

    always_comb begin
        req_ready  = (state == ST_IDLE) & ~rst;
        stall      = ~req_ready;
        resp_valid = (state == ST_RESP);
        mem_rd     = (state == ST_RD) & ~rst;
        mem_wr     = (state == ST_WR) & ~rst;
        mem_wdata  = (state == ST_WR) ? wdata_q : 32'h0;
        mem_addr   = (state == ST_IDLE) ? '0 : addr_q[ADDR_W+1:2];
    end

endmodule
